sprite_compositor: RTL and testbench

- Per-pixel RGB source for the VGA path. Composites NUM_SPRITES positionable bitmap sprites over a constant background colour.
- Sprite bitmaps live in on-chip RAM and are filled through a streaming load port. Sprite positions are double-buffered and take effect only at frame start.
- Sits between the VGA timing counter (x, y) and the DAC/RGB output registers.

---
 rtl/sprite_compositor_if.sv | 34 +++
 rtl/sprite_compositor.sv | 174 +++++++++++++++++
 tb/tb_sprite_compositor.sv | 293 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/sprite_compositor_if.sv
// Pixel, sprite-config, bitmap-load and RGB signals of sprite_compositor.
// Handshake: a load word transfers on each rising clk where ld_valid && ld_ready are both high.
interface sprite_compositor_if #(
    parameter int COORD_W = 10
);
    logic [COORD_W-1:0] x;
    logic [COORD_W-1:0] y;
    logic               cfg_we;
    logic [2:0]         cfg_sel;
    logic               cfg_en;
    logic [COORD_W-1:0] cfg_ox;
    logic [COORD_W-1:0] cfg_oy;
    logic               ld_start;
    logic [2:0]         ld_sel;
    logic               ld_valid;
    logic               ld_ready;
    logic [23:0]        ld_data;
    logic               ld_busy;
    logic [7:0]         red;
    logic [7:0]         green;
    logic [7:0]         blue;

    modport master (
        output x, y, cfg_we, cfg_sel, cfg_en, cfg_ox, cfg_oy,
        output ld_start, ld_sel, ld_valid, ld_data,
        input  ld_ready, ld_busy, red, green, blue
    );

    modport slave (
        input  x, y, cfg_we, cfg_sel, cfg_en, cfg_ox, cfg_oy,
        input  ld_start, ld_sel, ld_valid, ld_data,
        output ld_ready, ld_busy, red, green, blue
    );
endinterface

// File: rtl/sprite_compositor.sv
// Composites NUM_SPRITES colour-keyed bitmap sprites over a background, 2-cycle pixel latency.
// Optional ORIGIN_MARKER_EN forces pixel (0,0) to grey (150,150,150).
module sprite_compositor #(
    parameter int          IMG_W       = 48,
    parameter int          IMG_H       = 48,
    parameter int          NUM_SPRITES = 2,
    parameter int          COORD_W     = 10,
    parameter logic [23:0] BG_RGB      = 24'h2D7887,
    parameter logic [23:0] KEY_RGB     = 24'hFFFFFF
) (
    input logic                clk,
    input logic                rst,
    sprite_compositor_if.slave bus
);
    localparam int                 DEPTH    = IMG_W * IMG_H;
    localparam int                 ADDR_W   = $clog2(DEPTH);
    localparam logic [ADDR_W-1:0]  LAST     = ADDR_W'(DEPTH - 1);
    localparam logic [COORD_W:0]   IMG_W_E  = (COORD_W+1)'(IMG_W);
    localparam logic [COORD_W:0]   IMG_H_E  = (COORD_W+1)'(IMG_H);
    localparam logic [23:0]        MARK_RGB = 24'h969696;

    typedef enum logic {ST_IDLE, ST_LOAD} ld_state_t;

    ld_state_t         r_state;
    ld_state_t         w_next;
    logic [ADDR_W-1:0] r_cnt;
    logic [2:0]        r_sel;
    logic              w_load;
    logic              w_acc;
    logic              w_start_ok;
    logic              w_frame_start;
    logic              w_marker;
    logic [23:0]       w_rgb;

    logic [NUM_SPRITES-1:0]              r_pen_en, r_act_en;
    logic [NUM_SPRITES-1:0][COORD_W-1:0] r_pen_ox, r_pen_oy, r_act_ox, r_act_oy;
    logic [NUM_SPRITES-1:0]              w_hit_v;
    logic [NUM_SPRITES-1:0][23:0]        w_tex_v;

    assign w_start_ok    = bus.ld_start && ({1'b0, bus.ld_sel} < 4'(NUM_SPRITES));
    assign w_acc         = w_load && bus.ld_valid;
    assign w_frame_start = (bus.x == '0) && (bus.y == '0);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) r_state <= ST_IDLE;
        else     r_state <= w_next;
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            ST_IDLE: if (w_start_ok) w_next = ST_LOAD;
            ST_LOAD: if (w_acc && r_cnt == LAST) w_next = ST_IDLE;
            default: w_next = ST_IDLE;
        endcase
    end

    always_comb begin
        w_load       = (r_state == ST_LOAD);
        bus.ld_busy  = w_load;
        bus.ld_ready = w_load;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_cnt <= '0;
            r_sel <= '0;
        end else if (r_state == ST_IDLE && w_start_ok) begin
            r_cnt <= '0;
            r_sel <= bus.ld_sel;
        end else if (w_acc) begin
            r_cnt <= r_cnt + 1'b1;
        end
    end

    // Commit reads the old pending values, so a write in the commit cycle waits a frame.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_pen_en <= '0;
            r_pen_ox <= '0;
            r_pen_oy <= '0;
            r_act_en <= '0;
            r_act_ox <= '0;
            r_act_oy <= '0;
        end else begin
            if (w_frame_start) begin
                r_act_en <= r_pen_en;
                r_act_ox <= r_pen_ox;
                r_act_oy <= r_pen_oy;
            end
            for (int s = 0; s < NUM_SPRITES; s++) begin
                if (bus.cfg_we && bus.cfg_sel == 3'(s)) begin
                    r_pen_en[s] <= bus.cfg_en;
                    r_pen_ox[s] <= bus.cfg_ox;
                    r_pen_oy[s] <= bus.cfg_oy;
                end
            end
        end
    end

    for (genvar s = 0; s < NUM_SPRITES; s++) begin : g_slot
        logic [23:0]       r_mem [DEPTH];
        logic [COORD_W:0]  w_xe, w_ye, w_ox, w_oy, w_dx, w_dy;
        logic              w_hit;
        logic [ADDR_W-1:0] w_addr;
        logic              r_hit1, r_hit2;
        logic [ADDR_W-1:0] r_addr1;
        logic [23:0]       r_tex;

        // One extra bit keeps ox+IMG_W from wrapping past the right/bottom edge.
        always_comb begin
            w_xe   = {1'b0, bus.x};
            w_ye   = {1'b0, bus.y};
            w_ox   = {1'b0, r_act_ox[s]};
            w_oy   = {1'b0, r_act_oy[s]};
            w_dx   = w_xe - w_ox;
            w_dy   = w_ye - w_oy;
            w_hit  = r_act_en[s] && (w_xe >= w_ox) && (w_xe < w_ox + IMG_W_E)
                                 && (w_ye >= w_oy) && (w_ye < w_oy + IMG_H_E);
            w_addr = w_hit ? ADDR_W'(32'(w_dy) * IMG_W + 32'(w_dx)) : '0;
        end

        always_ff @(posedge clk) begin
            if (w_acc && r_sel == 3'(s)) r_mem[r_cnt] <= bus.ld_data;
        end

        always_ff @(posedge clk) begin
            r_tex <= r_mem[r_addr1];
        end

        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                r_hit1  <= 1'b0;
                r_addr1 <= '0;
                r_hit2  <= 1'b0;
            end else begin
                r_hit1  <= w_hit;
                r_addr1 <= w_addr;
                r_hit2  <= r_hit1;
            end
        end

        assign w_hit_v[s] = r_hit2;
        assign w_tex_v[s] = r_tex;
    end

`ifdef ORIGIN_MARKER_EN
    logic r_org1, r_org2;
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_org1 <= 1'b0;
            r_org2 <= 1'b0;
        end else begin
            r_org1 <= w_frame_start;
            r_org2 <= r_org1;
        end
    end
    assign w_marker = r_org2;
`else
    assign w_marker = 1'b0;
`endif

    // Scan high to low so the lowest-index opaque texel wins.
    always_comb begin
        w_rgb = BG_RGB;
        for (int s = NUM_SPRITES - 1; s >= 0; s--) begin
            if (w_hit_v[s] && w_tex_v[s] != KEY_RGB) w_rgb = w_tex_v[s];
        end
        if (w_marker) w_rgb = MARK_RGB;
        bus.red   = w_rgb[23:16];
        bus.green = w_rgb[15:8];
        bus.blue  = w_rgb[7:0];
    end
endmodule

// File: tb/tb_sprite_compositor.sv
// Directed bench for sprite_compositor: load, render, double buffering, priority, reset, edges.
module tb_sprite_compositor;
    localparam logic [23:0] BG   = 24'h2D7887;
    localparam int          NPIX = 2304;

    logic clk;
    logic rst;
    int   pass_cnt;
    int   total_cnt;

    sprite_compositor_if #(.COORD_W(10)) bus ();

    sprite_compositor dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [23:0] pat(input int kind, input int i);
        logic [31:0] iv;
        iv = 32'(i);
        case (kind)
            0:       return {8'd10, 8'd20, iv[7:0]};
            1:       return 24'h010203;
            2:       return (i < 1152) ? 24'hFFFFFF : 24'h090909;
            default: return 24'h0A0B0C;
        endcase
    endfunction

    task automatic show(input logic [9:0] px, input logic [9:0] py, output logic [23:0] rgb);
        @(negedge clk);
        bus.x = px;
        bus.y = py;
        @(posedge clk);
        @(posedge clk);
        #1;
        rgb = {bus.red, bus.green, bus.blue};
    endtask

    task automatic cfg(input logic [2:0] sel, input logic en, input logic [9:0] ox, input logic [9:0] oy);
        @(negedge clk);
        bus.cfg_we  = 1'b1;
        bus.cfg_sel = sel;
        bus.cfg_en  = en;
        bus.cfg_ox  = ox;
        bus.cfg_oy  = oy;
        @(negedge clk);
        bus.cfg_we  = 1'b0;
    endtask

    task automatic frame_start();
        @(negedge clk);
        bus.x = 10'd0;
        bus.y = 10'd0;
        @(negedge clk);
        bus.x = 10'd5;
        bus.y = 10'd5;
    endtask

    // Returns at the negedge after the last accepted word.
    task automatic load_slot(input logic [2:0] sel, input int kind, input bit toggle,
                             input bit restart, input int n_words, output int accepted);
        int  cyc;
        bit  v;
        @(negedge clk);
        bus.ld_start = 1'b1;
        bus.ld_sel   = sel;
        @(negedge clk);
        bus.ld_start = 1'b0;
        accepted = 0;
        cyc = 0;
        while (accepted < n_words && cyc < 6000) begin
            v = toggle ? (cyc % 2 == 0) : 1'b1;
            bus.ld_valid = v;
            bus.ld_data  = v ? pat(kind, accepted) : 24'hDEAD00;
            if (restart && cyc == 50) begin
                bus.ld_start = 1'b1;
                bus.ld_sel   = 3'd0;
            end else begin
                bus.ld_start = 1'b0;
            end
            if (v && bus.ld_ready) accepted++;
            cyc++;
            @(negedge clk);
        end
        bus.ld_valid = 1'b0;
        bus.ld_start = 1'b0;
    endtask

    task automatic test_reset();
        logic [23:0] rgb;
        #1;
        rgb = {bus.red, bus.green, bus.blue};
        total_cnt++;
        if (rgb !== BG) $display("FAIL reset_rgb got %h want %h", rgb, BG); else pass_cnt++;
        total_cnt++;
        if (bus.ld_busy !== 1'b0) $display("FAIL reset_busy got %b want 0", bus.ld_busy); else pass_cnt++;
        total_cnt++;
        if (bus.ld_ready !== 1'b0) $display("FAIL reset_ready got %b want 0", bus.ld_ready); else pass_cnt++;
        repeat (2) @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic test_load_render();
        int n;
        logic [23:0] rgb;
        load_slot(3'd0, 0, 1'b1, 1'b0, NPIX, n);
        total_cnt++;
        if (n !== NPIX) $display("FAIL load0_count got %0d want %0d", n, NPIX); else pass_cnt++;
        total_cnt++;
        if (bus.ld_busy !== 1'b0) $display("FAIL load0_busy_fall got %b want 0", bus.ld_busy); else pass_cnt++;
        cfg(3'd0, 1'b1, 10'd200, 10'd100);
        frame_start();
        show(10'd201, 10'd100, rgb);
        total_cnt++;
        if (rgb !== 24'h0A1401) $display("FAIL render_201_100 got %h want 0a1401", rgb); else pass_cnt++;
        show(10'd248, 10'd100, rgb);
        total_cnt++;
        if (rgb !== BG) $display("FAIL render_248_100 got %h want %h", rgb, BG); else pass_cnt++;
        show(10'd247, 10'd147, rgb);
        total_cnt++;
        if (rgb !== 24'h0A14FF) $display("FAIL render_last_texel got %h want 0a14ff", rgb); else pass_cnt++;
        show(10'd200, 10'd99, rgb);
        total_cnt++;
        if (rgb !== BG) $display("FAIL render_above got %h want %h", rgb, BG); else pass_cnt++;
    endtask

    task automatic test_double_buffer();
        logic [23:0] rgb;
        cfg(3'd0, 1'b1, 10'd0, 10'd0);
        show(10'd201, 10'd100, rgb);
        total_cnt++;
        if (rgb !== 24'h0A1401) $display("FAIL dbuf_old_pos got %h want 0a1401", rgb); else pass_cnt++;
        show(10'd1, 10'd1, rgb);
        total_cnt++;
        if (rgb !== BG) $display("FAIL dbuf_new_early got %h want %h", rgb, BG); else pass_cnt++;
        frame_start();
        show(10'd1, 10'd0, rgb);
        total_cnt++;
        if (rgb !== 24'h0A1401) $display("FAIL dbuf_new_pos got %h want 0a1401", rgb); else pass_cnt++;
        show(10'd201, 10'd100, rgb);
        total_cnt++;
        if (rgb !== BG) $display("FAIL dbuf_old_gone got %h want %h", rgb, BG); else pass_cnt++;
        @(negedge clk);
        bus.x = 10'd0;  bus.y = 10'd0;
        bus.cfg_we = 1'b1; bus.cfg_sel = 3'd0; bus.cfg_en = 1'b1;
        bus.cfg_ox = 10'd200; bus.cfg_oy = 10'd100;
        @(negedge clk);
        bus.cfg_we = 1'b0;
        bus.x = 10'd5;  bus.y = 10'd5;
        show(10'd1, 10'd0, rgb);
        total_cnt++;
        if (rgb !== 24'h0A1401) $display("FAIL dbuf_origin_cfg_held got %h want 0a1401", rgb); else pass_cnt++;
        frame_start();
        show(10'd201, 10'd100, rgb);
        total_cnt++;
        if (rgb !== 24'h0A1401) $display("FAIL dbuf_origin_cfg_applied got %h want 0a1401", rgb); else pass_cnt++;
    endtask

    task automatic test_priority();
        int n;
        logic [23:0] rgb;
        load_slot(3'd1, 1, 1'b0, 1'b1, NPIX, n);
        total_cnt++;
        if (n !== NPIX) $display("FAIL load1_count got %0d want %0d", n, NPIX); else pass_cnt++;
        total_cnt++;
        if (bus.ld_busy !== 1'b0) $display("FAIL load1_restart_ignored busy got %b want 0", bus.ld_busy); else pass_cnt++;
        load_slot(3'd0, 2, 1'b0, 1'b0, NPIX, n);
        total_cnt++;
        if (n !== NPIX) $display("FAIL load0b_count got %0d want %0d", n, NPIX); else pass_cnt++;
        cfg(3'd0, 1'b1, 10'd300, 10'd300);
        cfg(3'd1, 1'b1, 10'd300, 10'd300);
        cfg(3'd2, 1'b0, 10'd0, 10'd0);
        frame_start();
        show(10'd300, 10'd300, rgb);
        total_cnt++;
        if (rgb !== 24'h010203) $display("FAIL prio_key_fallthrough got %h want 010203", rgb); else pass_cnt++;
        show(10'd320, 10'd310, rgb);
        total_cnt++;
        if (rgb !== 24'h010203) $display("FAIL prio_key_mid got %h want 010203", rgb); else pass_cnt++;
        show(10'd300, 10'd330, rgb);
        total_cnt++;
        if (rgb !== 24'h090909) $display("FAIL prio_slot0_wins got %h want 090909", rgb); else pass_cnt++;
        show(10'd347, 10'd347, rgb);
        total_cnt++;
        if (rgb !== 24'h090909) $display("FAIL prio_corner got %h want 090909", rgb); else pass_cnt++;
    endtask

    task automatic test_reset_mid_load();
        int n;
        logic [23:0] rgb;
        show(10'd300, 10'd330, rgb);
        load_slot(3'd1, 3, 1'b0, 1'b0, 100, n);
        total_cnt++;
        if (bus.ld_busy !== 1'b1) $display("FAIL midload_busy got %b want 1", bus.ld_busy); else pass_cnt++;
        rst = 1'b1;
        #1;
        rgb = {bus.red, bus.green, bus.blue};
        total_cnt++;
        if (rgb !== BG) $display("FAIL midload_rst_rgb got %h want %h", rgb, BG); else pass_cnt++;
        total_cnt++;
        if (bus.ld_busy !== 1'b0) $display("FAIL midload_rst_busy got %b want 0", bus.ld_busy); else pass_cnt++;
        total_cnt++;
        if (bus.ld_ready !== 1'b0) $display("FAIL midload_rst_ready got %b want 0", bus.ld_ready); else pass_cnt++;
        @(negedge clk);
        rst = 1'b0;
        frame_start();
        show(10'd300, 10'd330, rgb);
        total_cnt++;
        if (rgb !== BG) $display("FAIL post_reset_no_sprite got %h want %h", rgb, BG); else pass_cnt++;
        cfg(3'd1, 1'b1, 10'd300, 10'd300);
        frame_start();
        show(10'd300, 10'd300, rgb);
        total_cnt++;
        if (rgb !== 24'h0A0B0C) $display("FAIL partial_word0 got %h want 0a0b0c", rgb); else pass_cnt++;
        show(10'd300, 10'd302, rgb);
        total_cnt++;
        if (rgb !== 24'h0A0B0C) $display("FAIL partial_word96 got %h want 0a0b0c", rgb); else pass_cnt++;
        show(10'd304, 10'd302, rgb);
        total_cnt++;
        if (rgb !== 24'h010203) $display("FAIL partial_word100 got %h want 010203", rgb); else pass_cnt++;
    endtask

    task automatic test_edge();
        logic [23:0] rgb;
        logic [9:0]  xs [4];
        cfg(3'd1, 1'b1, 10'd1013, 10'd500);
        frame_start();
        show(10'd1012, 10'd500, rgb);
        total_cnt++;
        if (rgb !== BG) $display("FAIL edge_left_of_ox got %h want %h", rgb, BG); else pass_cnt++;
        show(10'd1013, 10'd500, rgb);
        total_cnt++;
        if (rgb !== 24'h0A0B0C) $display("FAIL edge_at_ox got %h want 0a0b0c", rgb); else pass_cnt++;
        show(10'd1023, 10'd500, rgb);
        total_cnt++;
        if (rgb !== 24'h0A0B0C) $display("FAIL edge_last_col got %h want 0a0b0c", rgb); else pass_cnt++;
        xs[0] = 10'd0; xs[1] = 10'd20; xs[2] = 10'd36; xs[3] = 10'd37;
        for (int i = 0; i < 4; i++) begin
            show(xs[i], 10'd500, rgb);
            total_cnt++;
            if (rgb !== BG) $display("FAIL edge_no_wrap x=%0d got %h want %h", xs[i], rgb, BG); else pass_cnt++;
        end
        show(10'd1013, 10'd547, rgb);
        total_cnt++;
        if (rgb !== 24'h010203) $display("FAIL edge_bottom_row got %h want 010203", rgb); else pass_cnt++;
        show(10'd1013, 10'd548, rgb);
        total_cnt++;
        if (rgb !== BG) $display("FAIL edge_below got %h want %h", rgb, BG); else pass_cnt++;
    endtask

    task automatic test_origin();
        logic [23:0] rgb;
        logic [23:0] want;
`ifdef ORIGIN_MARKER_EN
        want = 24'h969696;
`else
        want = BG;
`endif
        show(10'd0, 10'd0, rgb);
        total_cnt++;
        if (rgb !== want) $display("FAIL origin_pixel got %h want %h", rgb, want); else pass_cnt++;
    endtask

    initial begin
        pass_cnt     = 0;
        total_cnt    = 0;
        rst          = 1'b1;
        bus.x        = 10'd5;
        bus.y        = 10'd5;
        bus.cfg_we   = 1'b0;
        bus.cfg_sel  = 3'd0;
        bus.cfg_en   = 1'b0;
        bus.cfg_ox   = 10'd0;
        bus.cfg_oy   = 10'd0;
        bus.ld_start = 1'b0;
        bus.ld_sel   = 3'd0;
        bus.ld_valid = 1'b0;
        bus.ld_data  = 24'd0;
        test_reset();
        test_load_render();
        test_double_buffer();
        test_priority();
        test_reset_mid_load();
        test_edge();
        test_origin();
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end
endmodule
